// File: rtl/cr16_fib_sequencer.sv
// cr16_fib_sequencer: fills a register file with a Fibonacci sequence.
// r0/r1 are loaded with the seed values, then each r[idx] = r[idx-2] + r[idx-1]
// is written one per enabled cycle, followed by a one-cycle DONE state.
// Continuous mode restarts from LOAD0 after every DONE.
module cr16_fib_sequencer #(
  parameter int          DATA_WIDTH = 16,
  parameter int          NUM_REGS   = 16,
  parameter int unsigned SEED0      = 1,
  parameter int unsigned SEED1      = 1
) (
  input  logic                              I_CLK,
  input  logic                              I_NRESET,
  input  logic                              I_START,
  input  logic                              I_ENABLE,
  input  logic                              I_ABORT,
  input  logic                              I_MODE,
  input  logic [$clog2(NUM_REGS)-1:0]       I_READ_SELECT,
  output logic [DATA_WIDTH-1:0]             O_READ_DATA,
  output logic [NUM_REGS-1:0]               O_WRITE_ENABLE,
  output logic [DATA_WIDTH-1:0]             O_RESULT,
  output logic                              O_BUSY,
  output logic                              O_DONE,
  output logic                              O_OVERFLOW,
  output logic [7:0]                        O_PASS_COUNT
);

  localparam int SW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD0 = 3'd1,
    S_LOAD1 = 3'd2,
    S_ADD   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         idx_q, idx_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            pass_q, pass_d;
  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];

  logic                  wr_en;
  logic [SW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [DATA_WIDTH:0]   sum;
  logic [SW-1:0]         idx_m1, idx_m2;
  logic                  busy, done;

  assign idx_m1 = idx_q - SW'(1);
  assign idx_m2 = idx_q - SW'(2);

  // Operand fetch for the adder and the external read port; unmatched addresses read 0
  always_comb begin
    op_a        = '0;
    op_b        = '0;
    O_READ_DATA = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx_m2 == SW'(i))        op_a        = rf_q[i];
      if (idx_m1 == SW'(i))        op_b        = rf_q[i];
      if (I_READ_SELECT == SW'(i)) O_READ_DATA = rf_q[i];
    end
  end

  assign sum = {1'b0, op_a} + {1'b0, op_b};

  // Next-state, write request and status decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    pass_d  = pass_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (I_START) begin
          state_d = S_LOAD0;
          ovf_d   = 1'b0;
          pass_d  = '0;
        end
      end
      S_LOAD0: begin
        busy = 1'b1;
        if (I_ABORT) begin
          state_d = S_IDLE;
        end else if (I_ENABLE) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          wr_data = DATA_WIDTH'(SEED0);
          state_d = S_LOAD1;
        end
      end
      S_LOAD1: begin
        busy = 1'b1;
        if (I_ABORT) begin
          state_d = S_IDLE;
        end else if (I_ENABLE) begin
          wr_en   = 1'b1;
          wr_addr = SW'(1);
          wr_data = DATA_WIDTH'(SEED1);
          idx_d   = SW'(2);
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        busy = 1'b1;
        if (I_ABORT) begin
          state_d = S_IDLE;
        end else if (I_ENABLE) begin
          wr_en   = 1'b1;
          wr_addr = idx_q;
          wr_data = sum[DATA_WIDTH-1:0];
          if (sum[DATA_WIDTH]) ovf_d = 1'b1;
          if (idx_q == SW'(NUM_REGS - 1)) state_d = S_DONE;
          else                            idx_d   = idx_q + SW'(1);
        end
      end
      S_DONE: begin
        done   = 1'b1;
        pass_d = pass_q + 8'd1;
        if (I_ABORT)     state_d = S_IDLE;
        else if (I_MODE) state_d = S_LOAD0;
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      pass_q  <= pass_d;
    end
  end

  // Register file: single write port driven by the FSM
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == SW'(i)) rf_q[i] <= wr_data;
      end
    end
  end

  // One-hot write strobe for the current cycle
  always_comb begin
    O_WRITE_ENABLE = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      O_WRITE_ENABLE[i] = wr_en && (wr_addr == SW'(i));
    end
  end

  assign O_RESULT     = wr_en ? wr_data : '0;
  assign O_BUSY       = busy;
  assign O_DONE       = done;
  assign O_OVERFLOW   = ovf_q;
  assign O_PASS_COUNT = pass_q;

endmodule

// File: tb/tb_cr16_fib_sequencer.sv
// Directed bench for cr16_fib_sequencer: default 16x16 instance plus a
// 25-deep instance for the carry-out case.
module tb_cr16_fib_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        a_start = 0, a_en = 0, a_abort = 0, a_mode = 0;
  logic [3:0]  a_sel = '0;
  logic [15:0] a_rd, a_we, a_res;
  logic        a_busy, a_done, a_ovf;
  logic [7:0]  a_pass;

  logic        b_start = 0, b_en = 0, b_abort = 0, b_mode = 0;
  logic [4:0]  b_sel = '0;
  logic [15:0] b_rd, b_res;
  logic [24:0] b_we;
  logic        b_busy, b_done, b_ovf;
  logic [7:0]  b_pass;

  int n_vec = 0;
  int n_err = 0;

  int unsigned fib [16] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987};

  always #5 clk = ~clk;

  cr16_fib_sequencer dut_a (
    .I_CLK(clk), .I_NRESET(rst_n), .I_START(a_start), .I_ENABLE(a_en),
    .I_ABORT(a_abort), .I_MODE(a_mode), .I_READ_SELECT(a_sel),
    .O_READ_DATA(a_rd), .O_WRITE_ENABLE(a_we), .O_RESULT(a_res),
    .O_BUSY(a_busy), .O_DONE(a_done), .O_OVERFLOW(a_ovf), .O_PASS_COUNT(a_pass)
  );

  cr16_fib_sequencer #(.DATA_WIDTH(16), .NUM_REGS(25)) dut_b (
    .I_CLK(clk), .I_NRESET(rst_n), .I_START(b_start), .I_ENABLE(b_en),
    .I_ABORT(b_abort), .I_MODE(b_mode), .I_READ_SELECT(b_sel),
    .O_READ_DATA(b_rd), .O_WRITE_ENABLE(b_we), .O_RESULT(b_res),
    .O_BUSY(b_busy), .O_DONE(b_done), .O_OVERFLOW(b_ovf), .O_PASS_COUNT(b_pass)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  // Edges from the current point until O_DONE is seen (bounded)
  task automatic run_to_done(output int n);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      n++;
      if (a_done) break;
    end
  endtask

  task automatic rd_a(input int unsigned addr, input int unsigned exp, input string tag);
    a_sel = 4'(addr);
    #1;
    chk(tag, 32'(a_rd), exp);
  endtask

  task automatic rd_b(input int unsigned addr, input int unsigned exp, input string tag);
    b_sel = 5'(addr);
    #1;
    chk(tag, 32'(b_rd), exp);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_we",   32'(a_we),   0);
    chk("rst_res",  32'(a_res),  0);
    chk("rst_ovf",  32'(a_ovf),  0);
    chk("rst_pass", 32'(a_pass), 0);
    chk("rst_r0",   32'(a_rd),   0);
    step();
    rst_n = 1'b1;
    a_en  = 1'b1;
    step();

    // Basic pass
    start_a();
    chk("t1_load0_we",  32'(a_we),   32'h1);
    chk("t1_load0_res", 32'(a_res),  1);
    chk("t1_busy",      32'(a_busy), 1);
    run_to_done(n);
    chk("t1_latency", n, 16);
    chk("t1_ovf", 32'(a_ovf), 0);
    step();
    chk("t1_pass", 32'(a_pass), 1);
    chk("t1_idle_busy", 32'(a_busy), 0);
    chk("t1_idle_done", 32'(a_done), 0);
    for (int i = 0; i < 16; i++) rd_a(i, fib[i], $sformatf("t1_r%0d", i));

    // Stall for three cycles at idx=5
    start_a();
    repeat (5) step();
    chk("t2_we_idx5", 32'(a_we),  32'h20);
    chk("t2_res_idx5", 32'(a_res), 8);
    a_en = 1'b0;
    #1;
    chk("t2_stall_we",   32'(a_we),   0);
    chk("t2_stall_res",  32'(a_res),  0);
    chk("t2_stall_busy", 32'(a_busy), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t2_stall_we_%0d", k), 32'(a_we), 0);
    end
    a_en = 1'b1;
    #1;
    chk("t2_resume_we", 32'(a_we), 32'h20);
    run_to_done(n);
    chk("t2_latency", 8 + n, 19);
    step();
    chk("t2_pass", 32'(a_pass), 1);
    rd_a(5, 8, "t2_r5");
    rd_a(15, 987, "t2_r15");

    // Start ignored while busy, then asynchronous reset mid-pass
    start_a();
    repeat (5) step();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("t3_start_ignored_we", 32'(a_we), 32'h40);
    #1 rst_n = 1'b0;
    #1;
    chk("t3_rst_busy", 32'(a_busy), 0);
    chk("t3_rst_we",   32'(a_we),   0);
    chk("t3_rst_res",  32'(a_res),  0);
    chk("t3_rst_pass", 32'(a_pass), 0);
    chk("t3_rst_ovf",  32'(a_ovf),  0);
    rd_a(15, 0, "t3_rst_r15");
    rd_a(1, 0, "t3_rst_r1");
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t3_wait_idle", 32'(a_busy), 0);

    // Abort during ADD at idx=7
    start_a();
    repeat (7) step();
    chk("t4_we_idx7", 32'(a_we), 32'h80);
    rd_a(7, 0, "t4_r7_old");
    a_abort = 1'b1;
    #1;
    chk("t4_abort_we",  32'(a_we),  0);
    chk("t4_abort_res", 32'(a_res), 0);
    step();
    a_abort = 1'b0;
    chk("t4_idle_busy", 32'(a_busy), 0);
    chk("t4_idle_done", 32'(a_done), 0);
    chk("t4_pass", 32'(a_pass), 0);
    rd_a(0, 1, "t4_r0");
    rd_a(6, 13, "t4_r6");
    rd_a(7, 0, "t4_r7");
    start_a();
    run_to_done(n);
    chk("t4_rerun_latency", n, 16);
    step();
    rd_a(7, 21, "t4_rerun_r7");
    rd_a(15, 987, "t4_rerun_r15");

    // Continuous mode, three passes
    a_mode = 1'b1;
    start_a();
    run_to_done(n);
    chk("t5_first", n, 16);
    step();
    run_to_done(n);
    chk("t5_period2", n + 1, 17);
    step();
    run_to_done(n);
    chk("t5_period3", n + 1, 17);
    chk("t5_pass_before", 32'(a_pass), 2);
    a_mode = 1'b0;
    step();
    chk("t5_pass", 32'(a_pass), 3);
    chk("t5_idle_busy", 32'(a_busy), 0);
    step();
    chk("t5_stay_idle", 32'(a_busy), 0);

    // 25-deep instance: carry out on the r24 write
    b_en = 1'b1;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    repeat (24) step();
    chk("b_we_idx24", 32'(b_we),  32'h0100_0000);
    chk("b_res_r24",  32'(b_res), 9489);
    chk("b_ovf_before", 32'(b_ovf), 0);
    step();
    chk("b_done", 32'(b_done), 1);
    chk("b_ovf_after", 32'(b_ovf), 1);
    step();
    chk("b_ovf_sticky", 32'(b_ovf), 1);
    rd_b(22, 28657, "b_r22");
    rd_b(23, 46368, "b_r23");
    rd_b(24, 9489, "b_r24");
    rd_b(25, 0, "b_r25_oor");
    rd_b(31, 0, "b_r31_oor");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cr16_fib_sequencer.md
CR16_FIB_SEQUENCER -- requirements
Module: cr16_fib_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: register/result width; SHALL be >= 2.
REQ-002 Parameter NUM_REGS, default 16: register-file depth; SHALL be 3..256. SW = $clog2(NUM_REGS).
REQ-003 Parameters SEED0 and SEED1, default 1 each: values written to r0 and r1.
REQ-004 Ports, clock and reset first:
- I_CLK  in  1  the single clock; all state changes on posedge.
- I_NRESET  in  1  reset, asynchronous, active-low.
- I_START  in  1  begin a sequence; sampled in IDLE only.
- I_ENABLE  in  1  step enable; low stalls the FSM with no write.
- I_ABORT  in  1  synchronous abort to IDLE.
- I_MODE  in  1  0 = one-shot, 1 = continuous.
- I_READ_SELECT  in  SW  register-file read address.
- O_READ_DATA  out  DATA_WIDTH  contents of the addressed register.
- O_WRITE_ENABLE  out  NUM_REGS  one-hot write strobe for the current cycle.
- O_RESULT  out  DATA_WIDTH  value being written this cycle.
- O_BUSY  out  1  sequence in progress.
- O_DONE  out  1  one-cycle pass-complete pulse.
- O_OVERFLOW  out  1  sticky carry-out flag.
- O_PASS_COUNT  out  8  completed-pass counter.

Function
REQ-005 The block SHALL contain a NUM_REGS x DATA_WIDTH register file, an index counter idx (SW bits) and a 5-state FSM: IDLE, LOAD0, LOAD1, ADD, DONE.
REQ-006 IDLE SHALL move to LOAD0 when I_START=1; START acceptance SHALL clear O_OVERFLOW and O_PASS_COUNT.
REQ-007 LOAD0 with I_ENABLE=1 SHALL write SEED0 to r0 and move to LOAD1.
REQ-008 LOAD1 with I_ENABLE=1 SHALL write SEED1 to r1, set idx=2 and move to ADD.
REQ-009 ADD with I_ENABLE=1 SHALL write r[idx] = (r[idx-2] + r[idx-1]) mod 2^DATA_WIDTH.
- A carry-out SHALL set O_OVERFLOW.
- The FSM SHALL go to DONE if idx==NUM_REGS-1, else increment idx.
REQ-010 DONE SHALL last exactly one cycle regardless of I_ENABLE and SHALL increment O_PASS_COUNT (255 wraps to 0).
- It SHALL then go to LOAD0 if I_MODE=1 at that edge, else to IDLE.
- O_OVERFLOW SHALL persist across continuous passes.
REQ-011 With I_ENABLE=0 in LOAD0, LOAD1 or ADD: no write, no state or idx change.
REQ-012 I_ABORT=1 in any non-IDLE state SHALL force IDLE at the next edge.
- Abort SHALL take priority over I_ENABLE and the write that cycle.
- Register-file contents, O_OVERFLOW and O_PASS_COUNT SHALL be retained.
REQ-013 O_WRITE_ENABLE SHALL be combinational.
- It SHALL be one-hot at the target register (r0, r1 or r[idx]) when the state is LOAD0, LOAD1 or ADD, I_ENABLE=1 and I_ABORT=0.
- It SHALL be zero otherwise.
REQ-014 O_RESULT SHALL equal the value being written whenever O_WRITE_ENABLE is nonzero, else 0.
REQ-015 O_BUSY SHALL be 1 in LOAD0, LOAD1 and ADD; O_DONE SHALL be 1 only in DONE; both combinational from state.
REQ-016 O_READ_DATA SHALL be a combinational read of r[I_READ_SELECT]; addresses >= NUM_REGS SHALL return 0.
- A read of the register being written returns the old value until the edge.
REQ-017 Latency: with I_ENABLE held 1, O_DONE SHALL be high in the cycle beginning NUM_REGS edges after the START-accepting edge.
REQ-018 I_START outside IDLE SHALL be ignored; I_MODE SHALL only matter at the DONE edge.

Reset
REQ-019 I_NRESET=0 SHALL immediately force, without waiting for a clock edge:
- FSM = IDLE, idx = 0, all registers = 0;
- O_OVERFLOW = 0, O_PASS_COUNT = 0;
- O_BUSY, O_DONE, O_WRITE_ENABLE and O_RESULT = 0.
REQ-020 Reset mid-sequence SHALL abandon the pass; after release the block waits in IDLE for I_START.

Verification
REQ-021 Defaults, START pulse, I_ENABLE=1 -> r0..r15 read 1,1,2,3,5,8,13,21,34,55,89,144,233,377,610,987; O_DONE high 16 cycles after acceptance; O_OVERFLOW=0; O_PASS_COUNT=1.
REQ-022 NUM_REGS=25, DATA_WIDTH=16 -> r23=46368; r24=75025 mod 65536=9489; O_OVERFLOW=1 from the r24 write edge.
REQ-023 I_ENABLE low 3 cycles during ADD at idx=5 -> no write strobes while low; final values identical; O_DONE delayed by exactly 3 cycles.
REQ-024 I_ABORT during ADD at idx=7 -> IDLE next cycle; r0..r6 kept; r7 not written; a later I_START reruns cleanly.
REQ-025 I_MODE=1 for 3 passes -> O_DONE pulses every 17 cycles; O_PASS_COUNT=3; then I_MODE=0 -> IDLE after the current pass.
REQ-026 I_NRESET low mid-pass -> all outputs and registers 0 immediately; I_START during busy is ignored.
